// File: rtl/maxpool_pkg.sv
// Shared definitions for the multi-channel max-pool block: FSM encoding and
// index/width helpers used by the top and its bench.
package maxpool_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit offset of element (c, r, k) in a flat LSB-first bus of h x h maps.
    function automatic int unsigned flat_idx(input int unsigned c, input int unsigned r,
                                             input int unsigned k, input int unsigned h,
                                             input int unsigned esz);
        return ((c * h + r) * h + k) * esz;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/maxpool_multichannel_max_compare.sv
// Combinational two-input maximum, signed or unsigned; ties return the shared value.
module max_compare #(
    parameter int ELEMENT_SIZE = 20,
    parameter int SIGNED       = 0
) (
    input  logic [ELEMENT_SIZE-1:0] a_i,
    input  logic [ELEMENT_SIZE-1:0] b_i,
    output logic [ELEMENT_SIZE-1:0] max_o
);
    logic a_wins;

    always_comb begin
        if (SIGNED != 0) a_wins = $signed(a_i) >= $signed(b_i);
        else             a_wins = a_i >= b_i;
        max_o = a_wins ? a_i : b_i;
    end

endmodule

// File: rtl/maxpool_multichannel.sv
// Sequential POOLxPOOL max-pooling over CHANNELS maps, one element per cycle.
//   state | meaning
//   IDLE  | waiting for en; input map captured into shadow on start
//   SCAN  | walking windows from the shadow copy, one element per cycle
//   DONE  | result valid, held until en drops
module maxpool_multichannel
    import maxpool_pkg::*;
#(
    parameter int IN_SIZE      = 26,
    parameter int ELEMENT_SIZE = 20,
    parameter int POOL         = 13,
    parameter int CHANNELS     = 1,
    parameter int SIGNED       = 0
) (
    input  logic                                                          clk,
    input  logic                                                          rst,
    input  logic                                                          en,
    input  logic [CHANNELS*IN_SIZE*IN_SIZE*ELEMENT_SIZE-1:0]              i_featuremap,
    output logic [CHANNELS*(IN_SIZE/POOL)*(IN_SIZE/POOL)*ELEMENT_SIZE-1:0] o_featuremap,
    output logic                                                          busy,
    output logic                                                          done
);
    localparam int OUT_SIZE = IN_SIZE / POOL;
    localparam int IN_BITS  = CHANNELS * IN_SIZE * IN_SIZE * ELEMENT_SIZE;
    localparam int OUT_BITS = CHANNELS * OUT_SIZE * OUT_SIZE * ELEMENT_SIZE;
    localparam int PW       = cnt_w(POOL);
    localparam int OW       = cnt_w(OUT_SIZE);
    localparam int CW       = cnt_w(CHANNELS);
    localparam int IOFF_W   = cnt_w(IN_BITS);
    localparam int OOFF_W   = cnt_w(OUT_BITS);
    localparam logic [PW-1:0] P_LAST = PW'(POOL - 1);
    localparam logic [OW-1:0] O_LAST = OW'(OUT_SIZE - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);

    if (OUT_SIZE < 1) begin : g_size_check
        $error("maxpool_multichannel: IN_SIZE/POOL must be at least 1");
    end

    state_t                    state_q, state_d;
    logic [IN_BITS-1:0]        shadow_q, shadow_d;
    logic [OUT_BITS-1:0]       out_q, out_d;
    logic [ELEMENT_SIZE-1:0]   acc_q, acc_d;
    logic [PW-1:0]             wx_q, wx_d, wy_q, wy_d;
    logic [OW-1:0]             ox_q, ox_d, oy_q, oy_d;
    logic [CW-1:0]             ch_q, ch_d;

    logic [IOFF_W-1:0]         rd_off;
    logic [OOFF_W-1:0]         wr_off;
    logic [ELEMENT_SIZE-1:0]   elem, cmp_a, elem_max;
    logic                      first_elem, last_elem, last_all;

    assign rd_off = IOFF_W'(flat_idx(32'(ch_q), 32'(oy_q) * POOL + 32'(wy_q),
                                     32'(ox_q) * POOL + 32'(wx_q), IN_SIZE, ELEMENT_SIZE));
    assign wr_off = OOFF_W'(flat_idx(32'(ch_q), 32'(oy_q), 32'(ox_q), OUT_SIZE, ELEMENT_SIZE));
    assign elem       = shadow_q[rd_off +: ELEMENT_SIZE];
    assign first_elem = (wx_q == '0) && (wy_q == '0);
    assign last_elem  = (wx_q == P_LAST) && (wy_q == P_LAST);
    assign last_all   = last_elem && (ox_q == O_LAST) && (oy_q == O_LAST) && (ch_q == C_LAST);
    assign cmp_a      = first_elem ? elem : acc_q;

    max_compare #(.ELEMENT_SIZE(ELEMENT_SIZE), .SIGNED(SIGNED)) u_cmp (
        .a_i  (cmp_a),
        .b_i  (elem),
        .max_o(elem_max)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en) state_d = SCAN;
            SCAN:    if (last_all) state_d = DONE;
            DONE:    if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SCAN);
        done = (state_q == DONE);
    end

    // Counter order, fastest first: wx, wy, ox, oy, ch.
    always_comb begin
        shadow_d = shadow_q;
        out_d    = out_q;
        acc_d    = acc_q;
        wx_d     = wx_q;
        wy_d     = wy_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        ch_d     = ch_q;
        if (state_q == IDLE && en) begin
            shadow_d = i_featuremap;
            wx_d     = '0;
            wy_d     = '0;
            ox_d     = '0;
            oy_d     = '0;
            ch_d     = '0;
        end else if (state_q == SCAN) begin
            acc_d = elem_max;
            if (last_elem) out_d[wr_off +: ELEMENT_SIZE] = elem_max;
            if (wx_q != P_LAST) wx_d = wx_q + 1'b1;
            else begin
                wx_d = '0;
                if (wy_q != P_LAST) wy_d = wy_q + 1'b1;
                else begin
                    wy_d = '0;
                    if (ox_q != O_LAST) ox_d = ox_q + 1'b1;
                    else begin
                        ox_d = '0;
                        if (oy_q != O_LAST) oy_d = oy_q + 1'b1;
                        else begin
                            oy_d = '0;
                            ch_d = (ch_q != C_LAST) ? ch_q + 1'b1 : '0;
                        end
                    end
                end
            end
        end
    end

    // The shadow copy is only read after a start loads it, so it carries no reset.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            acc_q <= '0;
            wx_q  <= '0;
            wy_q  <= '0;
            ox_q  <= '0;
            oy_q  <= '0;
            ch_q  <= '0;
        end else begin
            out_q <= out_d;
            acc_q <= acc_d;
            wx_q  <= wx_d;
            wy_q  <= wy_d;
            ox_q  <= ox_d;
            oy_q  <= oy_d;
            ch_q  <= ch_d;
        end
    end

    assign o_featuremap = out_q;

endmodule

// File: tb/tb_maxpool_multichannel.sv
// Scoreboard bench: default-size instance plus signed/unsigned 5x5 two-channel instances.
module tb_maxpool_multichannel;
    localparam int ES   = 20;
    localparam int A_IN = 26, A_P = 13, A_CH = 1, A_OUT = A_IN / A_P;
    localparam int A_IW = A_CH * A_IN * A_IN * ES, A_OW = A_CH * A_OUT * A_OUT * ES;
    localparam int A_N  = A_CH * A_OUT * A_OUT * A_P * A_P;
    localparam int S_IN = 5, S_P = 2, S_CH = 2, S_OUT = S_IN / S_P;
    localparam int S_IW = S_CH * S_IN * S_IN * ES, S_OW = S_CH * S_OUT * S_OUT * ES;
    localparam int S_N  = S_CH * S_OUT * S_OUT * S_P * S_P;

    typedef logic [ES-1:0] elem_t;
    typedef elem_t elem_arr_t[];
    typedef struct { logic [A_OW-1:0] exp; int unsigned st; } a_ent_t;
    typedef struct { int id; logic [S_OW-1:0] exp; int unsigned st; } s_ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_a = 1'b0;
    logic [A_IW-1:0] ifm_a = '0;
    logic [A_OW-1:0] ofm_a;
    logic busy_a, done_a;
    logic [1:0] en_s = 2'b00;
    logic [S_IW-1:0] ifm_s [2];
    logic [S_OW-1:0] ofm_s [2];
    logic [1:0] busy_s, done_s;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    a_ent_t sb_a[$];
    s_ent_t sb_s[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    maxpool_multichannel #(.IN_SIZE(A_IN), .ELEMENT_SIZE(ES), .POOL(A_P), .CHANNELS(A_CH), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .en(en_a), .i_featuremap(ifm_a),
        .o_featuremap(ofm_a), .busy(busy_a), .done(done_a));
    maxpool_multichannel #(.IN_SIZE(S_IN), .ELEMENT_SIZE(ES), .POOL(S_P), .CHANNELS(S_CH), .SIGNED(1)) u_dut_sgn (
        .clk(clk), .rst(rst), .en(en_s[0]), .i_featuremap(ifm_s[0]),
        .o_featuremap(ofm_s[0]), .busy(busy_s[0]), .done(done_s[0]));
    maxpool_multichannel #(.IN_SIZE(S_IN), .ELEMENT_SIZE(ES), .POOL(S_P), .CHANNELS(S_CH), .SIGNED(0)) u_dut_uns (
        .clk(clk), .rst(rst), .en(en_s[1]), .i_featuremap(ifm_s[1]),
        .o_featuremap(ofm_s[1]), .busy(busy_s[1]), .done(done_s[1]));

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int ix(input int c, input int r, input int k, input int h);
        return (c * h + r) * h + k;
    endfunction

    // Reference: for every window take the largest element by plain comparison.
    function automatic elem_arr_t pool_ref(input elem_arr_t m, input int in, input int p,
                                           input int nch, input bit sgn);
        int out = in / p;
        elem_arr_t o = new[nch * out * out];
        for (int c = 0; c < nch; c++)
            for (int oy = 0; oy < out; oy++)
                for (int ox = 0; ox < out; ox++) begin
                    elem_t best = m[ix(c, oy * p, ox * p, in)];
                    for (int wy = 0; wy < p; wy++)
                        for (int wx = 0; wx < p; wx++) begin
                            elem_t e = m[ix(c, oy * p + wy, ox * p + wx, in)];
                            if (sgn ? ($signed(e) > $signed(best)) : (e > best)) best = e;
                        end
                    o[ix(c, oy, ox, out)] = best;
                end
        return o;
    endfunction

    function automatic elem_arr_t rand_map(input int n);
        elem_arr_t m = new[n];
        for (int i = 0; i < n; i++) m[i] = elem_t'($urandom());
        return m;
    endfunction

    function automatic elem_arr_t t2_map();
        elem_arr_t m = new[A_IN * A_IN];
        for (int r = 0; r < A_IN; r++)
            for (int k = 0; k < A_IN; k++) m[ix(0, r, k, A_IN)] = (r < 13) ? elem_t'(k + 1) : elem_t'(1);
        return m;
    endfunction

    // 4x4 pattern in the top-left; row/col 4 hold a value that must be ignored.
    function automatic elem_arr_t t3_map(input elem_t trail);
        elem_arr_t m = new[S_CH * S_IN * S_IN];
        for (int c = 0; c < S_CH; c++)
            for (int r = 0; r < S_IN; r++)
                for (int k = 0; k < S_IN; k++)
                    m[ix(c, r, k, S_IN)] = (r == 4 || k == 4) ? trail : 20'hFFFFB;
        m[ix(0, 1, 1, S_IN)] = 20'hFFFFF;
        m[ix(1, 3, 3, S_IN)] = 20'd7;
        return m;
    endfunction

    function automatic elem_arr_t t6_map();
        elem_arr_t m = new[S_CH * S_IN * S_IN];
        for (int c = 0; c < S_CH; c++)
            for (int r = 0; r < S_IN; r++)
                for (int k = 0; k < S_IN; k++)
                    m[ix(c, r, k, S_IN)] = (r == 4 || k == 4) ? elem_t'(99) : elem_t'(3);
        return m;
    endfunction

    task automatic start_a(input elem_arr_t m);
        a_ent_t ent;
        elem_arr_t e = pool_ref(m, A_IN, A_P, A_CH, 1'b0);
        @(negedge clk);
        for (int i = 0; i < A_CH * A_IN * A_IN; i++) ifm_a[i*ES +: ES] = m[i];
        for (int i = 0; i < A_CH * A_OUT * A_OUT; i++) ent.exp[i*ES +: ES] = e[i];
        en_a = 1'b1;
        @(posedge clk);
        #1;
        ent.st = cyc;
        sb_a.push_back(ent);
    endtask

    task automatic wait_done_a(input int budget);
        int n = 0;
        while (!done_a && n < budget) begin @(negedge clk); n++; end
        if (!done_a) check("a_timeout", 256'(done_a), 256'(1));
    endtask

    task automatic run_a(input elem_arr_t m);
        start_a(m);
        wait_done_a(A_N + 20);
        @(negedge clk);
        en_a = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_s(input int id, input elem_arr_t m);
        s_ent_t ent;
        int n = 0;
        elem_arr_t e = pool_ref(m, S_IN, S_P, S_CH, id == 0);
        @(negedge clk);
        for (int i = 0; i < S_CH * S_IN * S_IN; i++) ifm_s[id][i*ES +: ES] = m[i];
        for (int i = 0; i < S_CH * S_OUT * S_OUT; i++) ent.exp[i*ES +: ES] = e[i];
        ent.id = id;
        en_s[id] = 1'b1;
        @(posedge clk);
        #1;
        ent.st = cyc;
        sb_s.push_back(ent);
        while (!done_s[id] && n < S_N + 20) begin @(negedge clk); n++; end
        if (!done_s[id]) check("s_timeout", 256'(done_s[id]), 256'(1));
        @(negedge clk);
        en_s[id] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    logic done_a_q = 1'b0;
    a_ent_t mon_a;
    always @(negedge clk) begin
        if (done_a && !done_a_q) begin
            if (sb_a.size() == 0) check("a_unexpected_done", 256'(done_a), 256'(0));
            else begin
                mon_a = sb_a.pop_front();
                check("a_out", 256'(ofm_a), 256'(mon_a.exp));
                check("a_latency", 256'(cyc - mon_a.st), 256'(A_N));
                check("a_busy_at_done", 256'(busy_a), 256'(0));
            end
        end
        done_a_q <= done_a;
    end

    logic [1:0] done_s_q = 2'b00;
    s_ent_t mon_s;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (done_s[i] && !done_s_q[i]) begin
                if (sb_s.size() == 0) check("s_unexpected_done", 256'(done_s[i]), 256'(0));
                else begin
                    mon_s = sb_s.pop_front();
                    check($sformatf("s%0d_id", i), 256'(i), 256'(mon_s.id));
                    check($sformatf("s%0d_out", i), 256'(ofm_s[i]), 256'(mon_s.exp));
                    check($sformatf("s%0d_latency", i), 256'(cyc - mon_s.st), 256'(S_N));
                end
            end
        end
        done_s_q <= done_s;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        ifm_s[0] = '0;
        ifm_s[1] = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 256'(busy_a), 256'(0));
        check("rst_done", 256'(done_a), 256'(0));
        check("rst_out", 256'(ofm_a), 256'(0));
        check("rst_out_s", 256'({ofm_s[0], ofm_s[1]}), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", 256'(busy_a), 256'(0));
        check("idle_done", 256'(done_a), 256'(0));

        run_a(t2_map());
        check("t2_out00", 256'(ofm_a[0*ES +: ES]), 256'(13));
        check("t2_out01", 256'(ofm_a[1*ES +: ES]), 256'(26));
        check("t2_out10", 256'(ofm_a[2*ES +: ES]), 256'(1));
        check("t2_out11", 256'(ofm_a[3*ES +: ES]), 256'(1));

        // Reset in the middle of a scan discards the run entirely.
        start_a(rand_map(A_IN * A_IN));
        repeat (100) @(negedge clk);
        rst = 1'b1;
        en_a = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", 256'(busy_a), 256'(0));
        check("midrst_done", 256'(done_a), 256'(0));
        check("midrst_out", 256'(ofm_a), 256'(0));
        void'(sb_a.pop_back());
        @(negedge clk);
        rst = 1'b0;
        run_a(t2_map());

        // Input and en changes during SCAN are ignored; done holds while en is high.
        start_a(rand_map(A_IN * A_IN));
        repeat (50) @(negedge clk);
        for (int i = 0; i < A_IN * A_IN; i++) ifm_a[i*ES +: ES] = elem_t'($urandom());
        en_a = 1'b0;
        repeat (200) @(negedge clk);
        check("scan_ignores_en", 256'(busy_a), 256'(1));
        en_a = 1'b1;
        wait_done_a(A_N);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("done_hold", 256'(done_a), 256'(1));
        end
        en_a = 1'b0;
        @(posedge clk);
        #1;
        check("done_release", 256'(done_a), 256'(0));

        for (int t = 0; t < 2; t++) run_a(rand_map(A_IN * A_IN));

        run_s(0, t3_map(20'h7FFFF));
        check("t3s_ch0_00", 256'(ofm_s[0][0*ES +: ES]), 256'(20'hFFFFF));
        check("t3s_ch0_01", 256'(ofm_s[0][1*ES +: ES]), 256'(20'hFFFFB));
        check("t3s_ch1_11", 256'(ofm_s[0][7*ES +: ES]), 256'(7));
        check("t3s_ch1_00", 256'(ofm_s[0][4*ES +: ES]), 256'(20'hFFFFB));
        run_s(1, t3_map(20'd0));
        check("t3u_ch0_00", 256'(ofm_s[1][0*ES +: ES]), 256'(20'hFFFFF));
        check("t3u_ch1_11", 256'(ofm_s[1][7*ES +: ES]), 256'(20'hFFFFB));
        run_s(1, t6_map());
        for (int i = 0; i < S_CH * S_OUT * S_OUT; i++)
            check($sformatf("t6_slot%0d", i), 256'(ofm_s[1][i*ES +: ES]), 256'(3));
        for (int t = 0; t < 3; t++) begin
            run_s(0, rand_map(S_CH * S_IN * S_IN));
            run_s(1, rand_map(S_CH * S_IN * S_IN));
        end

        repeat (3) @(negedge clk);
        check("sb_a_drained", 256'(sb_a.size()), 256'(0));
        check("sb_s_drained", 256'(sb_s.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
